// File: rtl/alu_pkg.sv
// Shared types for the ALU opcode issue stage: widths, FSM states and the queued instruction.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StHold
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } instr_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous instruction FIFO with registered occupancy; full/empty derive from the count only.
module op_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  instr_t wdata,
  input  logic   pop,
  output instr_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  instr_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_op_issue.sv
// Opcode issue stage: queues instructions, presents each to the decoder/ALU for a settle window,
// then captures the ALU result and offers it downstream over valid/ready.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              dec_a,
  output logic              dec_b,
  output logic              dec_c,
  output logic              dec_d,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OP_W-1:0]   res_op,
  output logic [DATA_W-1:0] res_y,
  output logic              res_cout,
  output logic              busy
);

  localparam int unsigned CtrW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CtrW-1:0] CtrLoad = CtrW'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [CtrW-1:0]   ctr_q, ctr_d;
  instr_t            issue_q, issue_d;
  logic              res_valid_q, res_valid_d;
  logic [OP_W-1:0]   res_op_q, res_op_d;
  logic [DATA_W-1:0] res_y_q, res_y_d;
  logic              res_cout_q, res_cout_d;

  instr_t fifo_head;
  instr_t fifo_wdata;
  logic   fifo_full, fifo_empty;
  logic   fifo_pop;

  assign fifo_wdata = '{op: in_op, a: in_a, b: in_b};

  op_fifo #(
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    issue_d     = issue_q;
    res_valid_d = res_valid_q;
    res_op_d    = res_op_q;
    res_y_d     = res_y_q;
    res_cout_d  = res_cout_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          issue_d  = fifo_head;
          ctr_d    = CtrLoad;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (ctr_q == '0) state_d = StCapture;
        else             ctr_d   = ctr_q - CtrW'(1);
      end
      StCapture: begin
        res_y_d     = alu_y;
        res_cout_d  = alu_cout;
        res_op_d    = issue_q.op;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ctr_q       <= '0;
      issue_q     <= '0;
      res_valid_q <= 1'b0;
      res_op_q    <= '0;
      res_y_q     <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      issue_q     <= issue_d;
      res_valid_q <= res_valid_d;
      res_op_q    <= res_op_d;
      res_y_q     <= res_y_d;
      res_cout_q  <= res_cout_d;
    end
  end

  // Decoder select lines: dec_a is the opcode MSB.
  assign {dec_a, dec_b, dec_c, dec_d} = issue_q.op;
  assign alu_a     = issue_q.a;
  assign alu_b     = issue_q.b;
  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_y     = res_y_q;
  assign res_cout  = res_cout_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule
